// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: takes 16-bit instruction words over valid/ready and decodes them.
// Drives the shared combinational ALU, holds the operands for EXEC_CYCLES cycles, then
// writes the result into a 4 x 32-bit register file.
// Optional macro ALU_SEQ_IMM_OPS_EN turns ops 1001..1111 into immediate forms.
module alu_op_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  output logic [3:0]  alu_en,
  input  logic [31:0] alu_result,
  input  logic        alu_z,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        z_flag,
  input  logic [1:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;
  typedef enum logic [1:0] {KindNop, KindLdi, KindAlu, KindIll} kind_e;

  localparam logic [3:0] ExecLoad = 4'(EXEC_CYCLES - 1);

  state_e      r_state;
  kind_e       r_kind;
  logic [15:0] r_instr;
  logic [31:0] r_regs [4];
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_res;
  logic [2:0]  r_alu_control;
  logic [3:0]  r_alu_en;
  logic [3:0]  r_cnt;
  logic        r_res_z;
  logic        r_done;
  logic        r_illegal;
  logic        r_z_flag;

  logic [3:0]  w_op;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs1;
  logic [1:0]  w_rs2;
  logic [5:0]  w_imm;
  logic [31:0] w_opnd_b;
  kind_e       w_kind;
  logic [2:0]  w_ctrl;
  logic [3:0]  w_en;
`ifdef ALU_SEQ_IMM_OPS_EN
  logic        w_use_imm;
`endif

  assign w_op  = r_instr[15:12];
  assign w_rd  = r_instr[11:10];
  assign w_rs1 = r_instr[9:8];
  assign w_rs2 = r_instr[7:6];
  assign w_imm = r_instr[5:0];

  // Classify the latched op; register and immediate forms share control = op[2:0] - 1
  always_comb begin
    w_kind = KindIll;
    w_ctrl = w_op[2:0] - 3'd1;
`ifdef ALU_SEQ_IMM_OPS_EN
    w_use_imm = 1'b0;
`endif
    if (w_op == 4'b0000) begin
      w_kind = KindNop;
    end else if (w_op == 4'b1000) begin
      w_kind = KindLdi;
    end else if (!w_op[3]) begin
      w_kind = KindAlu;
    end else begin
`ifdef ALU_SEQ_IMM_OPS_EN
      w_kind    = KindAlu;
      w_use_imm = 1'b1;
`else
      w_kind = KindIll;
`endif
    end
    case (w_ctrl)
      3'd0, 3'd1:       w_en = 4'b0001;
      3'd2, 3'd3, 3'd4: w_en = 4'b0010;
      3'd5, 3'd6:       w_en = 4'b0100;
      default:          w_en = 4'b0000;
    endcase
  end

`ifdef ALU_SEQ_IMM_OPS_EN
  assign w_opnd_b = w_use_imm ? {26'b0, w_imm} : r_regs[w_rs2];
`else
  assign w_opnd_b = r_regs[w_rs2];
`endif

  // Sequencer FSM with registered ALU drive, status pulses and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_kind        <= KindNop;
      r_instr       <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_res         <= '0;
      r_alu_control <= 3'b000;
      r_alu_en      <= 4'b0000;
      r_cnt         <= '0;
      r_res_z       <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_z_flag      <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        StIdle: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          r_kind <= w_kind;
          if (w_kind == KindAlu) begin
            r_alu_a       <= r_regs[w_rs1];
            r_alu_b       <= w_opnd_b;
            r_alu_control <= w_ctrl;
            r_alu_en      <= w_en;
            r_cnt         <= ExecLoad;
            r_state       <= StExec;
          end else begin
            r_done    <= 1'b1;
            r_illegal <= (w_kind == KindIll);
            r_state   <= StWb;
          end
        end
        StExec: begin
          if (r_cnt == 4'd0) begin
            r_res    <= alu_result;
            r_res_z  <= alu_z;
            r_alu_en <= 4'b0000;
            r_done   <= 1'b1;
            r_state  <= StWb;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StWb: begin
          r_state <= StIdle;
          case (r_kind)
            KindLdi: r_regs[w_rd] <= {26'b0, w_imm};
            KindAlu: begin
              r_regs[w_rd] <= r_res;
              r_z_flag     <= r_res_z;
            end
            default: ;
          endcase
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign instr_ready = (r_state == StIdle) && !rst;
  assign busy        = (r_state != StIdle);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_control;
  assign alu_en      = r_alu_en;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign z_flag      = r_z_flag;
  assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (EXEC_CYCLES 1 and 4) fed the same
// instruction stream in lockstep, each with its own behavioural ALU.
module tb_alu_op_sequencer;

  localparam int E1 = 1;
  localparam int E4 = 4;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic [1:0]  dbg_sel;

  logic        ready1, busy1, done1, ill1, zf1, alu_z1;
  logic [31:0] a1, b1, res1, dbg1;
  logic [2:0]  ctrl1;
  logic [3:0]  en1;
  logic        ready4, busy4, done4, ill4, zf4, alu_z4;
  logic [31:0] a4, b4, res4, dbg4;
  logic [2:0]  ctrl4;
  logic [3:0]  en4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_regs [4];
  logic        m_z;

  alu_op_sequencer #(.EXEC_CYCLES(E1)) u_dut1 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(ready1), .instr(instr),
    .alu_a(a1), .alu_b(b1), .alu_control(ctrl1), .alu_en(en1), .alu_result(res1),
    .alu_z(alu_z1), .busy(busy1), .done(done1), .illegal(ill1), .z_flag(zf1),
    .dbg_sel(dbg_sel), .dbg_data(dbg1)
  );

  alu_op_sequencer #(.EXEC_CYCLES(E4)) u_dut4 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(ready4), .instr(instr),
    .alu_a(a4), .alu_b(b4), .alu_control(ctrl4), .alu_en(en4), .alu_result(res4),
    .alu_z(alu_z4), .busy(busy4), .done(done4), .illegal(ill4), .z_flag(zf4),
    .dbg_sel(dbg_sel), .dbg_data(dbg4)
  );

  // Team ALU stand-in
  function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b;
      3'd6: return a >> b;
      default: return 32'd0;
    endcase
  endfunction

  assign res1   = alu_f(ctrl1, a1, b1);
  assign alu_z1 = (res1 == 32'd0);
  assign res4   = alu_f(ctrl4, a4, b4);
  assign alu_z4 = (res4 == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Architectural model: what one instruction does to the visible state
  task automatic model_apply(input logic [15:0] w, output bit is_alu, output bit is_ill,
                             output logic [2:0] ctrl, output logic [3:0] en);
    int unsigned opn;
    logic [31:0] a, b, r;
    opn    = int'(w[15:12]);
    is_alu = 1'b0;
    is_ill = 1'b0;
    ctrl   = 3'd0;
    en     = 4'd0;
    a      = m_regs[w[9:8]];
    b      = m_regs[w[7:6]];
    if (opn == 0) begin
    end else if (opn == 8) begin
      m_regs[w[11:10]] = {26'd0, w[5:0]};
    end else begin
      if (opn > 8) begin
`ifdef ALU_SEQ_IMM_OPS_EN
        b   = {26'd0, w[5:0]};
        opn = opn - 8;
`else
        is_ill = 1'b1;
`endif
      end
      if (!is_ill) begin
        is_alu = 1'b1;
        ctrl   = 3'(opn - 1);
        case (opn)
          1: r = a + b;
          2: r = a - b;
          3: r = a & b;
          4: r = a | b;
          5: r = a ^ b;
          6: r = (b > 31) ? 32'd0 : a << b[4:0];
          default: r = (b > 31) ? 32'd0 : a >> b[4:0];
        endcase
        en = (opn <= 2) ? 4'b0001 : (opn <= 5) ? 4'b0010 : 4'b0100;
        m_regs[w[11:10]] = r;
        m_z = (r == 32'd0);
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      check({tag, "_reg1"}, dbg1, m_regs[r]);
      check({tag, "_reg4"}, dbg4, m_regs[r]);
    end
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!(ready1 && ready4) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 50) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one instruction to both instances and check timing, pulses and final state
  task automatic issue(input logic [15:0] w, output logic obs_ill);
    bit is_alu, is_ill, en_ok, ill_ok;
    logic [2:0] e_ctrl;
    logic [3:0] e_en;
    int lat1, lat4, enc1, enc4, dc1, dc4;
    logic il1, il4;
    wait_ready();
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    model_apply(w, is_alu, is_ill, e_ctrl, e_en);
    lat1 = -1; lat4 = -1; enc1 = 0; enc4 = 0; dc1 = 0; dc4 = 0;
    en_ok = 1'b1; ill_ok = 1'b1; il1 = 1'b0; il4 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (en1 != 4'd0) begin enc1++; if (en1 != e_en) en_ok = 1'b0; end
      if (en4 != 4'd0) begin enc4++; if (en4 != e_en) en_ok = 1'b0; end
      if ((ill1 && !done1) || (ill4 && !done4)) ill_ok = 1'b0;
      if (done1) begin dc1++; if (lat1 < 0) begin lat1 = k; il1 = ill1; end end
      if (done4) begin dc4++; if (lat4 < 0) begin lat4 = k; il4 = ill4; end end
      if (k > 0 && ready1 && ready4 && lat1 >= 0 && lat4 >= 0) break;
    end
    check("lat1", 32'(lat1), is_alu ? 32'(E1 + 1) : 32'd1);
    check("lat4", 32'(lat4), is_alu ? 32'(E4 + 1) : 32'd1);
    check("done_width1", 32'(dc1), 32'd1);
    check("done_width4", 32'(dc4), 32'd1);
    check("illegal1", {31'd0, il1}, {31'd0, is_ill});
    check("illegal4", {31'd0, il4}, {31'd0, is_ill});
    check("illegal_only_with_done", {31'd0, ill_ok}, 32'd1);
    check("en_cycles1", 32'(enc1), is_alu ? 32'(E1) : 32'd0);
    check("en_cycles4", 32'(enc4), is_alu ? 32'(E4) : 32'd0);
    check("en_class", {31'd0, en_ok}, 32'd1);
    if (is_alu) begin
      check("ctrl1", {29'd0, ctrl1}, {29'd0, e_ctrl});
      check("ctrl4", {29'd0, ctrl4}, {29'd0, e_ctrl});
    end
    check("z_flag1", {31'd0, zf1}, {31'd0, m_z});
    check("z_flag4", {31'd0, zf4}, {31'd0, m_z});
    check_regs("model");
    obs_ill = il1;
  endtask

  typedef struct {
    logic [15:0] w;
    int          ridx;
    logic [31:0] val;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t tbl [19];

  task automatic run_vec(input int i);
    logic oi;
    issue(tbl[i].w, oi);
    dbg_sel = 2'(tbl[i].ridx);
    #1;
    check("tbl_reg1", dbg1, tbl[i].val);
    check("tbl_reg4", dbg4, tbl[i].val);
    check("tbl_z1", {31'd0, zf1}, {31'd0, tbl[i].z});
    check("tbl_z4", {31'd0, zf4}, {31'd0, tbl[i].z});
    check("tbl_ill", {31'd0, oi}, {31'd0, tbl[i].ill});
  endtask

  initial begin
    logic [15:0] w;
    logic oi;
    int xf1, xf4, dn, wide, rdy_bad;
    logic prev;

    // Plan sequence A
    tbl[0] = '{16'h8405, 1, 32'd5,  1'b0, 1'b0};   // LDI r1,5
    tbl[1] = '{16'h8805, 2, 32'd5,  1'b0, 1'b0};   // LDI r2,5
    tbl[2] = '{16'h2D80, 3, 32'd0,  1'b1, 1'b0};   // SUB r3,r1,r2
    tbl[3] = '{16'h8803, 2, 32'd3,  1'b1, 1'b0};   // LDI r2,3
    tbl[4] = '{16'h6180, 0, 32'd40, 1'b0, 1'b0};   // SHL r0,r1,r2
`ifdef ALU_SEQ_IMM_OPS_EN
    tbl[5] = '{16'h9907, 2, 32'd12, 1'b0, 1'b0};   // ADDI r2,r1,#7
`else
    tbl[5] = '{16'h9907, 2, 32'd3,  1'b0, 1'b1};   // op 1001: illegal
`endif
    tbl[6] = '{16'h0000, 0, 32'd40, 1'b0, 1'b0};   // NOP
    // Sequence B: build r1=0xF0F0, r2=0x0FF0, then AND
    tbl[7]  = '{16'h843C, 1, 32'd60,      1'b0, 1'b0};
    tbl[8]  = '{16'h8802, 2, 32'd2,       1'b0, 1'b0};
    tbl[9]  = '{16'h6580, 1, 32'h0000_00F0, 1'b0, 1'b0};
    tbl[10] = '{16'h8C08, 3, 32'd8,       1'b0, 1'b0};
    tbl[11] = '{16'h61C0, 0, 32'h0000_F000, 1'b0, 1'b0};
    tbl[12] = '{16'h4440, 1, 32'h0000_F0F0, 1'b0, 1'b0};
    tbl[13] = '{16'h883F, 2, 32'd63,      1'b0, 1'b0};
    tbl[14] = '{16'h8C06, 3, 32'd6,       1'b0, 1'b0};
    tbl[15] = '{16'h6AC0, 2, 32'h0000_0FC0, 1'b0, 1'b0};
    tbl[16] = '{16'h8030, 0, 32'd48,      1'b0, 1'b0};
    tbl[17] = '{16'h4A00, 2, 32'h0000_0FF0, 1'b0, 1'b0};
    tbl[18] = '{16'h3180, 0, 32'h0000_00F0, 1'b0, 1'b0};

    for (int r = 0; r < 4; r++) m_regs[r] = 32'd0;
    m_z = 1'b0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'd0;
    dbg_sel = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1 | done4}, 32'd0);
    check("rst_en", {28'd0, en1}, 32'd0);
    check("rst_a", a1, 32'd0);
    check("rst_b", b4, 32'd0);
    check("rst_ctrl", {29'd0, ctrl1}, 32'd0);
    check("rst_ready", {31'd0, ready1 & ready4}, 32'd1);
    check_regs("rst");

    for (int i = 0; i <= 6; i++) run_vec(i);

    // Reset while both instances are in EXEC of an ADD
    wait_ready();
    instr = 16'h1180;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("exec_en1", {28'd0, en1}, 32'b0001);
    check("exec_en4", {28'd0, en4}, 32'b0001);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) m_regs[r] = 32'd0;
    m_z = 1'b0;
    check("rst_exec_busy", {30'd0, busy1, busy4}, 32'd0);
    check("rst_exec_en", {24'd0, en1, en4}, 32'd0);
    check("rst_exec_pulse", {28'd0, done1, done4, ill1, ill4}, 32'd0);
    check("rst_exec_ready_low", {30'd0, ready1, ready4}, 32'd0);
    check_regs("rst_exec");
    rst = 1'b0;
    #1;
    check("rst_exec_ready", {30'd0, ready1, ready4}, 32'b11);
    @(posedge clk); #1;
    check("rst_exec_no_done", {30'd0, done1, done4}, 32'd0);

    // instr_valid held high across three LDI r3,9
    instr = 16'h8C09;
    instr_valid = 1'b1;
    xf1 = 0; xf4 = 0; dn = 0; wide = 0; rdy_bad = 0; prev = 1'b0;
    for (int k = 0; k < 60 && xf1 < 3; k++) begin
      if (ready1) xf1++;
      if (ready4) xf4++;
      if ((busy1 && ready1) || (busy4 && ready4)) rdy_bad++;
      if (done1) begin dn++; if (prev) wide++; end
      prev = done1;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ready1) rdy_bad = rdy_bad + 0;
      if (busy1 && ready1) rdy_bad++;
      if (done1) begin dn++; if (prev) wide++; end
      prev = done1;
      @(posedge clk); #1;
    end
    m_regs[3] = 32'd9;
    check("b2b_xfers1", 32'(xf1), 32'd3);
    check("b2b_xfers4", 32'(xf4), 32'd3);
    check("b2b_dones", 32'(dn), 32'd3);
    check("b2b_wide", 32'(wide), 32'd0);
    check("b2b_ready_busy", 32'(rdy_bad), 32'd0);
    check_regs("b2b");

    for (int i = 7; i <= 18; i++) run_vec(i);

    // Random instruction stream against the model
    for (int n = 0; n < 80; n++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'h8;
      issue(w, oi);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
